pmod_io_ctrl: RTL

PMOD_IO_CTRL -- requirements
Module: pmod_io_ctrl

---
 rtl/pmod_io_ctrl_if.sv | 29 ++
 rtl/pmod_io_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pmod_io_ctrl_if.sv
// Board-side bundle for pmod_io_ctrl: button pins, display inputs, and LED/display outputs.
interface pmod_io_ctrl_if #(
   parameter int unsigned N_BTN    = 4,
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned LED_W    = 16
);
   logic [N_BTN-1:0]      buttons_i;
   logic [4*N_DIGITS-1:0] digits_i;
   logic [N_DIGITS-1:0]   dp_i;
   logic [N_DIGITS-1:0]   blank_i;
   logic [LED_W-1:0]      leds_i;
   logic [N_BTN-1:0]      btn_level_o;
   logic [N_BTN-1:0]      btn_press_o;
   logic [7:0]            seven_seg_o;
   logic [N_DIGITS-1:0]   digit_sel_o;
   logic [LED_W-1:0]      leds_o;

   // Driver side (board / testbench).
   modport master (
      output buttons_i, digits_i, dp_i, blank_i, leds_i,
      input  btn_level_o, btn_press_o, seven_seg_o, digit_sel_o, leds_o
   );

   // Controller side.
   modport slave (
      input  buttons_i, digits_i, dp_i, blank_i, leds_i,
      output btn_level_o, btn_press_o, seven_seg_o, digit_sel_o, leds_o
   );
endinterface

// File: rtl/pmod_io_ctrl.sv
// PMOD I/O controller: debounced buttons, multiplexed seven-segment display, registered LEDs.
module pmod_io_ctrl #(
   parameter int unsigned N_BTN           = 4,
   parameter int unsigned N_DIGITS        = 4,
   parameter int unsigned LED_W           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SCAN_CYCLES     = 50000,
   parameter int unsigned ACTIVE_LOW      = 1
) (
   input logic            clk_i,
   input logic            rst_n_i,
   pmod_io_ctrl_if.slave  bus
);
   localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned PS_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic             POL      = (ACTIVE_LOW != 0);

   logic [N_BTN-1:0]    btn_raw_c;
   logic [N_BTN-1:0]    sync1_q, sync2_q;
   logic [N_BTN-1:0]    level_q, press_q;
   logic [DB_W-1:0]     cnt_q [N_BTN];
   logic [PS_W-1:0]     pre_q;
   logic [IDX_W-1:0]    idx_q;
   logic [3:0]          hex_c;
   logic                dp_c, blank_c;
   logic [6:0]          glyph_c;
   logic [7:0]          seg_c, seg_q;
   logic [N_DIGITS-1:0] sel_c, sel_q;
   logic [LED_W-1:0]    led_q;

   assign btn_raw_c = bus.buttons_i ^ {N_BTN{POL}};

   // Synchronise buttons and accept a level change only after DEBOUNCE_CYCLES stable mismatches.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         press_q <= '0;
         for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_raw_c;
         sync2_q <= sync1_q;
         for (int i = 0; i < int'(N_BTN); i++) begin
            press_q[i] <= 1'b0;
            if (sync2_q[i] == level_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DB_LAST) begin
               cnt_q[i]   <= '0;
               level_q[i] <= ~level_q[i];
               press_q[i] <= ~level_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Scan prescaler; the digit index steps on each terminal count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pre_q <= '0;
         idx_q <= '0;
      end else if (pre_q == PS_LAST) begin
         pre_q <= '0;
         idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
         pre_q <= pre_q + PS_W'(1);
      end
   end

   // Pick the currently scanned digit's nibble, decimal point and blank flag.
   always_comb begin
      hex_c   = '0;
      dp_c    = 1'b0;
      blank_c = 1'b0;
      for (int d = 0; d < int'(N_DIGITS); d++) begin
         if (idx_q == IDX_W'(d)) begin
            hex_c   = bus.digits_i[4*d +: 4];
            dp_c    = bus.dp_i[d];
            blank_c = bus.blank_i[d];
         end
      end
   end

   // Hex to {g..a} glyph.
   always_comb begin
      glyph_c = 7'h00;
      case (hex_c)
         4'h0: glyph_c = 7'h3F;
         4'h1: glyph_c = 7'h06;
         4'h2: glyph_c = 7'h5B;
         4'h3: glyph_c = 7'h4F;
         4'h4: glyph_c = 7'h66;
         4'h5: glyph_c = 7'h6D;
         4'h6: glyph_c = 7'h7D;
         4'h7: glyph_c = 7'h07;
         4'h8: glyph_c = 7'h7F;
         4'h9: glyph_c = 7'h6F;
         4'hA: glyph_c = 7'h77;
         4'hB: glyph_c = 7'h7C;
         4'hC: glyph_c = 7'h39;
         4'hD: glyph_c = 7'h5E;
         4'hE: glyph_c = 7'h79;
         default: glyph_c = 7'h71;
      endcase
   end

   assign seg_c = blank_c ? 8'h00 : {dp_c, glyph_c};
   assign sel_c = N_DIGITS'(1) << idx_q;

   // Select, segments and LEDs registered together so select and segments stay aligned.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sel_q <= '0;
         seg_q <= '0;
         led_q <= '0;
      end else begin
         sel_q <= sel_c;
         seg_q <= seg_c;
         led_q <= bus.leds_i;
      end
   end

   assign bus.btn_level_o = level_q;
   assign bus.btn_press_o = press_q;
   assign bus.seven_seg_o = seg_q ^ {8{POL}};
   assign bus.digit_sel_o = sel_q ^ {N_DIGITS{POL}};
   assign bus.leds_o      = led_q ^ {LED_W{POL}};
endmodule
